// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: IP, one Feistel round per clock with an on-the-fly
// key schedule (PC1, per-round rotate, PC2), then FP. The f-function is external.
module des_iter_ctrl #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] in_data,
  input  logic [1:64] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] out_data,
  output logic [1:32] f_r,
  output logic [1:48] f_k,
  input  logic [1:32] f_out,
  output logic        busy,
  output logic [4:0]  round_cnt
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [6:0] IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam logic [6:0] FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam logic [6:0] PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam logic [5:0] PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Table-driven bit gathers; each shifts selected source bits in MSB first.
  function automatic logic [1:64] ip_f(input logic [1:64] d);
    logic [1:64] o;
    o = '0;
    for (int i = 0; i < 64; i++) o = {o[2:64], d[IP_T[i]]};
    return o;
  endfunction

  function automatic logic [1:64] fp_f(input logic [1:64] d);
    logic [1:64] o;
    o = '0;
    for (int i = 0; i < 64; i++) o = {o[2:64], d[FP_T[i]]};
    return o;
  endfunction

  function automatic logic [1:56] pc1_f(input logic [1:64] d);
    logic [1:56] o;
    o = '0;
    for (int i = 0; i < 56; i++) o = {o[2:56], d[PC1_T[i]]};
    return o;
  endfunction

  function automatic logic [1:48] pc2_f(input logic [1:56] d);
    logic [1:48] o;
    o = '0;
    for (int i = 0; i < 48; i++) o = {o[2:48], d[PC2_T[i]]};
    return o;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [1:32] l_q, l_d, r_q, r_d;
  logic [1:56] cd_q, cd_d;
  logic        dec_q, dec_d;
  logic [1:64] out_q, out_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;

  logic [1:28] c_cur, d_cur, c_nxt, d_nxt;
  logic [1:56] cd_nxt;
  logic [1:0]  shift;
  logic        sched_one;
  logic        unused_parity;

  assign unused_parity = ^{in_key[8], in_key[16], in_key[24], in_key[32],
                           in_key[40], in_key[48], in_key[56], in_key[64]};

  // Per-round key rotation; decrypt walks the encrypt schedule backwards.
  always_comb begin
    c_cur     = cd_q[1:28];
    d_cur     = cd_q[29:56];
    sched_one = (round_q == 5'd2) || (round_q == 5'd9) || (round_q == 5'd16);
    if (dec_q) shift = (round_q == 5'd1) ? 2'd0 : (sched_one ? 2'd1 : 2'd2);
    else       shift = ((round_q == 5'd1) || sched_one) ? 2'd1 : 2'd2;
    case (shift)
      2'd1: begin
        c_nxt = dec_q ? {c_cur[28], c_cur[1:27]} : {c_cur[2:28], c_cur[1]};
        d_nxt = dec_q ? {d_cur[28], d_cur[1:27]} : {d_cur[2:28], d_cur[1]};
      end
      2'd2: begin
        c_nxt = dec_q ? {c_cur[27:28], c_cur[1:26]} : {c_cur[3:28], c_cur[1:2]};
        d_nxt = dec_q ? {d_cur[27:28], d_cur[1:26]} : {d_cur[3:28], d_cur[1:2]};
      end
      default: begin
        c_nxt = c_cur;
        d_nxt = d_cur;
      end
    endcase
    cd_nxt = {c_nxt, d_nxt};
  end

  assign f_r = r_q;
  assign f_k = pc2_f(cd_nxt);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    l_d     = l_q;
    r_d     = r_q;
    cd_d    = cd_q;
    dec_d   = dec_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = ip_f(in_data);
          cd_d       = pc1_f(in_key);
          dec_d      = in_decrypt;
          round_d    = 5'd1;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        cd_d    = cd_nxt;
        l_d     = r_q;
        r_d     = l_q ^ f_out;
        round_d = round_q + 5'd1;
        if (round_q == 5'(ROUNDS)) begin
          out_d   = fp_f({l_q ^ f_out, r_q});
          round_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_q     <= '0;
      l_q         <= '0;
      r_q         <= '0;
      cd_q        <= '0;
      dec_q       <= 1'b0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      l_q         <= l_d;
      r_q         <= r_d;
      cd_q        <= cd_d;
      dec_q       <= dec_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign round_cnt = round_q;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Bench for des_iter_ctrl: supplies the DES f-function and compares results
// against a whole-block DES model with precomputed cumulative-shift subkeys.
module tb_des_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:64] in_data;
  logic [1:64] in_key;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [1:64] out_data;
  logic [1:32] f_r;
  logic [1:48] f_k;
  logic [1:32] f_out;
  logic        busy;
  logic [4:0]  round_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  int ip_t[$] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                  62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                  57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                  61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  int fp_t[$] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                  38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                  36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                  34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  int pc1_t[$] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                   10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                   63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                   14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int pc2_t[$] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                   23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                   41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                   44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int e_t[$] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  int p_t[$] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  logic [255:0] sbox_t [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Gather bits of an nin-bit right-justified word; table entries are 1-based from the MSB.
  function automatic logic [63:0] perm(input logic [63:0] d, input int nin, input int t[$]);
    logic [63:0] o;
    o = '0;
    foreach (t[j]) o = {o[62:0], d[nin - t[j]]};
    return o;
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input int n);
    logic [55:0] y;
    y = {x, x} << n;
    return y[55:28];
  endfunction

  function automatic logic [31:0] ffunc(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] x;
    logic [31:0] s;
    logic [5:0]  six;
    int          n;
    x = perm({32'h0, r}, 32, e_t) ^ {16'h0, k};
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      n   = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
      s   = {s[27:0], sbox_t[b][255-4*n -: 4]};
    end
    return 32'(perm({32'h0, s}, 32, p_t));
  endfunction

  // Subkey for round rnd: PC1, rotate each half by the running shift total, PC2.
  function automatic logic [47:0] subkey(input logic [63:0] key, input int rnd);
    logic [63:0] cd;
    int          tot;
    cd  = perm(key, 64, pc1_t);
    tot = 0;
    for (int i = 1; i <= rnd; i++) tot += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
    return 48'(perm({8'h0, rol28(cd[55:28], tot), rol28(cd[27:0], tot)}, 56, pc2_t));
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] data, input bit dec);
    logic [63:0] ipd;
    logic [31:0] l, r, t;
    ipd = perm(data, 64, ip_t);
    l   = ipd[63:32];
    r   = ipd[31:0];
    for (int i = 1; i <= 16; i++) begin
      t = r;
      r = l ^ ffunc(r, subkey(key, dec ? 17 - i : i));
      l = t;
    end
    return perm({r, l}, 64, fp_t);
  endfunction

  assign f_out = ffunc(f_r, f_k);

  des_iter_ctrl #(.ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .f_r(f_r), .f_k(f_k), .f_out(f_out), .busy(busy), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One job: accept, 16 checked rounds, optional stall in DONE, then handshake.
  task automatic run_job(input string tag, input logic [63:0] key, input logic [63:0] data,
                         input bit dec, input int stall, input bit poke);
    logic [63:0] exp;
    exp = des_model(key, data, dec);
    @(negedge clk);
    chk({tag, "/accept_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = data; in_key = key; in_decrypt = dec; out_ready = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_data = ~data; in_key = ~key; in_decrypt = ~dec;
      end
      in_valid = poke && (k == 3 || k == 10);
      if (in_valid) begin
        in_data = {$urandom, $urandom}; in_key = {$urandom, $urandom};
      end
      chk({tag, "/round_cnt"}, 64'(round_cnt), 64'(k));
      chk({tag, "/out_valid_low"}, 64'(out_valid), 64'd0);
      chk({tag, "/busy_round"}, 64'(busy), 64'd1);
      chk({tag, "/in_ready_round"}, 64'(in_ready), 64'd0);
      chk({tag, "/f_k"}, 64'(f_k), 64'(subkey(key, dec ? 17 - k : k)));
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "/out_valid_t17"}, 64'(out_valid), 64'd1);
    chk({tag, "/out_data"}, out_data, exp);
    chk({tag, "/round_cnt_done"}, 64'(round_cnt), 64'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "/stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "/stall_data"}, out_data, exp);
      chk({tag, "/stall_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "/stall_busy"}, 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "/idle_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "/idle_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "/idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] exp_q[$];
    logic [63:0] k_r, d_r;
    bit          acc;
    int          got, last, bj;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; in_decrypt = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset/in_ready", 64'(in_ready), 64'd1);
    chk("reset/out_valid", 64'(out_valid), 64'd0);
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/round_cnt", 64'(round_cnt), 64'd0);
    chk("reset/out_data", out_data, 64'd0);

    // Known-answer vectors, then long backpressure with ignored input pulses.
    run_job("fips_enc", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 0, 1'b0);
    chk("fips_enc/model", des_model(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0), 64'h85E813540F0AB405);
    run_job("fips_dec", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 0, 1'b0);
    chk("fips_dec/model", des_model(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1), 64'h0123456789ABCDEF);
    run_job("stall40", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 40, 1'b1);

    // Reset in round 8 aborts the job with no output.
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h0123456789ABCDEF; in_key = 64'h133457799BBCDFF1; in_decrypt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst/round8", 64'(round_cnt), 64'd8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/round_cnt", 64'(round_cnt), 64'd0);
    chk("midrst/out_valid", 64'(out_valid), 64'd0);
    chk("midrst/in_ready", 64'(in_ready), 64'd1);
    chk("midrst/busy", 64'(busy), 64'd0);
    chk("midrst/out_data", out_data, 64'd0);
    repeat (20) @(negedge clk);
    chk("midrst/no_output", 64'(out_valid), 64'd0);
    run_job("after_rst", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      k_r = {$urandom, $urandom};
      d_r = {$urandom, $urandom};
      run_job("rand", k_r, d_r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)));
    end

    // Back-to-back: in_valid and out_ready held high across four jobs.
    out_ready = 1'b1;
    bj = 0; got = 0; last = 0;
    k_r = {$urandom, $urandom}; d_r = {$urandom, $urandom};
    in_valid = 1'b1; in_key = k_r; in_data = d_r; in_decrypt = 1'b0;
    exp_q.push_back(des_model(k_r, d_r, 1'b0));
    acc = in_ready;
    for (int cyc = 1; cyc < 200 && got < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("b2b/out_data", out_data, exp_q[got]);
        if (got > 0) chk("b2b/spacing", 64'(cyc - last), 64'd18);
        last = cyc;
        got++;
      end
      if (acc) begin
        bj++;
        if (bj < 4) begin
          k_r = {$urandom, $urandom}; d_r = {$urandom, $urandom};
          in_key = k_r; in_data = d_r;
          exp_q.push_back(des_model(k_r, d_r, 1'b0));
        end else begin
          in_valid = 1'b0;
        end
      end
      acc = in_valid && in_ready;
    end
    chk("b2b/results", 64'(got), 64'd4);
    out_ready = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
